// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small byte FIFO with a
// valid/ready pop port and sticky framing / overrun error flags.
module uart_rx_fifo #(
   parameter int CLOCK_RATE = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  rd_ready,
   output logic                  rd_valid,
   output logic [7:0]            rd_data,
   output logic [DEPTH_LOG2:0]   level,
   input  logic                  clear_errors,
   output logic                  frame_error,
   output logic                  overrun,
   output logic                  busy
);

   localparam int DIV   = CLOCK_RATE / BAUD_RATE;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = $clog2(DIV);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
   localparam logic [LW-1:0]    LEVEL_FULL = LW'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // ---------------------------------------------------------------
   // Input synchronizer
   // ---------------------------------------------------------------
   logic rx_meta;
   logic rxs;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make both flops sample the old
         // values, giving a true two-stage shift instead of a single wire.
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // ---------------------------------------------------------------
   // Receiver FSM
   // ---------------------------------------------------------------
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             stop_sample;
   logic             push;
   logic             frame_evt;

   assign stop_sample = (state == STOP) && (cnt == '0);
   assign push        = stop_sample && rxs;
   assign frame_evt   = stop_sample && !rxs;
   assign busy        = (state != IDLE);

   // Bit-timing state machine: half-bit to the start-bit centre, then
   // one full bit period between every later sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= CNT_HALF;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (rxs) begin
                     // Line went back high before mid-bit: treat as a glitch.
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     cnt     <= CNT_FULL;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shift[bit_idx] <= rxs;
                  cnt            <= CNT_FULL;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STOP: begin
               // The stop sample is taken mid-bit, so IDLE is re-entered
               // early enough to catch a back-to-back start bit.
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Byte FIFO
   // ---------------------------------------------------------------
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  full;
   logic                  pop;
   logic                  wr_en;
   logic                  drop;

   assign full     = (level == LEVEL_FULL);
   assign rd_valid = (level != '0);
   assign pop      = rd_valid && rd_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // still succeeds.
   assign wr_en    = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign rd_data  = mem[rd_ptr];

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; level/rd_valid gate every read, so
      // stale contents are never observed and the array maps to plain RAM.
      if (wr_en) begin
         mem[wr_ptr] <= shift;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------

   // A new error event takes priority over a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (frame_evt) begin
            frame_error <= 1'b1;
         end else if (clear_errors) begin
            frame_error <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (clear_errors) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with DIV=16, HALF=8,
// four-entry FIFO.
module tb_uart_rx_fifo;

   localparam int CLOCK_RATE = 16;
   localparam int BAUD_RATE  = 1;
   localparam int DEPTH_LOG2 = 2;
   localparam int DIV        = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rd_ready = 1'b0;
   logic       clear_errors = 1'b0;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [2:0] level;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int lat;
   logic seen_busy;

   uart_rx_fifo #(
      .CLOCK_RATE (CLOCK_RATE),
      .BAUD_RATE  (BAUD_RATE),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .level        (level),
      .clear_errors (clear_errors),
      .frame_error  (frame_error),
      .overrun      (overrun),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one 8N1 frame; called at a falling edge, returns at one.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop_bit;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check(tag, 32'(rd_data), 32'(exp));
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Reset
      idle(3);
      rst = 1'b0;
      idle(2);
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ferr", 32'(frame_error), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);

      // Single byte, latency measured from the start edge
      fork
         send_frame(8'hA5, 1'b1);
         begin
            lat = 0;
            while (!rd_valid && lat < 300) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check("a5_latency_155pm1", 32'(lat >= 154 && lat <= 156), 32'd1);
      idle(2);
      check("a5_data", 32'(rd_data), 32'hA5);
      check("a5_level", 32'(level), 32'd1);
      check("a5_ferr", 32'(frame_error), 32'd0);
      check("a5_ovr", 32'(overrun), 32'd0);
      check("a5_busy", 32'(busy), 32'd0);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      check("a5_pop_level", 32'(level), 32'd0);
      check("a5_pop_valid", 32'(rd_valid), 32'd0);
      idle(20);

      // Back-to-back fill plus one extra byte -> overrun
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      send_frame(8'h81, 1'b1);
      send_frame(8'h55, 1'b1);
      idle(2);
      check("fill_level", 32'(level), 32'd4);
      check("fill_ovr", 32'(overrun), 32'd1);
      check("fill_ferr", 32'(frame_error), 32'd0);
      pop_expect("fill_pop0", 8'h00);
      pop_expect("fill_pop1", 8'hFF);
      pop_expect("fill_pop2", 8'h3C);
      pop_expect("fill_pop3", 8'h81);
      check("fill_empty", 32'(rd_valid), 32'd0);
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);
      idle(20);

      // Start-bit glitch
      seen_busy = 1'b0;
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
      end
      check("glitch_busy_seen", 32'(seen_busy), 32'd1);
      check("glitch_busy_end", 32'(busy), 32'd0);
      check("glitch_level", 32'(level), 32'd0);
      check("glitch_ferr", 32'(frame_error), 32'd0);
      check("glitch_ovr", 32'(overrun), 32'd0);

      // Framing error, clear, then a good byte
      send_frame(8'h5A, 1'b0);
      idle(20);
      check("ferr_set", 32'(frame_error), 32'd1);
      check("ferr_level", 32'(level), 32'd0);
      check("ferr_busy", 32'(busy), 32'd0);
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
      check("ferr_cleared", 32'(frame_error), 32'd0);
      send_frame(8'h12, 1'b1);
      idle(2);
      check("after_ferr_level", 32'(level), 32'd1);
      pop_expect("after_ferr_pop", 8'h12);
      check("after_ferr_flag", 32'(frame_error), 32'd0);
      idle(20);

      // Full FIFO with a pop landing on the push edge
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      idle(2);
      check("full_level", 32'(level), 32'd4);
      fork
         send_frame(8'h77, 1'b1);
         begin
            repeat (154) @(negedge clk);
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
         end
      join
      idle(2);
      check("sim_ovr", 32'(overrun), 32'd0);
      check("sim_level", 32'(level), 32'd4);
      pop_expect("sim_pop0", 8'h22);
      pop_expect("sim_pop1", 8'h33);
      pop_expect("sim_pop2", 8'h44);
      pop_expect("sim_pop3", 8'h77);
      check("sim_empty", 32'(rd_valid), 32'd0);
      idle(20);

      // Asynchronous reset mid-frame with bytes stored
      send_frame(8'hE1, 1'b1);
      send_frame(8'hE2, 1'b1);
      idle(2);
      check("prerst_level", 32'(level), 32'd2);
      fork
         send_frame(8'hB4, 1'b1);
         begin
            repeat (88) @(negedge clk);
            check("prerst_busy", 32'(busy), 32'd1);
            rst = 1'b1;
            #1;
            check("arst_level", 32'(level), 32'd0);
            check("arst_valid", 32'(rd_valid), 32'd0);
            check("arst_busy", 32'(busy), 32'd0);
         end
      join
      idle(2);
      rst = 1'b0;
      idle(4);
      send_frame(8'hC3, 1'b1);
      idle(2);
      check("post_rst_level", 32'(level), 32'd1);
      pop_expect("post_rst_pop", 8'hC3);
      check("post_rst_ferr", 32'(frame_error), 32'd0);
      check("post_rst_ovr", 32'(overrun), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
